// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution pipeline: default pixel width,
// default window height, and the counter-width helper used by every stage
// that addresses columns or rows.
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int CONV_IMG_WIDTH = 16;  // default pixel bit width
    localparam int CONV_IMG_NB    = 3;   // default rows per column vector

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : conv_pkg

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// One image-row delay: a simple dual-port RAM of IMG_COLS pixels with a
// combinational read port and a synchronous write port sharing one address.
// Reading and writing the same address in one cycle returns the old
// contents (read-before-write), so the value written one row ago comes out
// while the new pixel goes in.
//
// Ports
//   clk    in   write clock
//   wr_en  in   write enable (one accepted pixel)
//   addr   in   column address, shared by read and write
//   din    in   pixel written at addr
//   dout   out  pixel stored at addr before this cycle's write
// ---------------------------------------------------------------------------
module line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH = CONV_IMG_WIDTH,
    parameter int IMG_COLS  = 64
) (
    input  logic                            clk,
    input  logic                            wr_en,
    input  logic [cnt_width(IMG_COLS)-1:0]  addr,
    input  logic [IMG_WIDTH-1:0]            din,
    output logic [IMG_WIDTH-1:0]            dout
);

    logic [IMG_WIDTH-1:0] mem [IMG_COLS];

    // NOTE: the storage array has no reset; clearing a RAM would block
    // inference, and stale rows are hidden by the row gating upstream.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule : line_buffer

// File: rtl/pixel_window.sv
// ---------------------------------------------------------------------------
// pixel_window
// Turns a raster pixel stream into vertical column vectors of IMG_NB pixels
// for the downstream convolution stage. Slot 0 of img is the current pixel,
// slot k is the pixel at the same column k rows earlier. Outputs are
// registered: they update on the edge that accepts the pixel.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst        in   asynchronous active-high reset
//   pixel      in   raster-order input pixel
//   pixel_val  in   pixel qualifier
//   sof        in   start of frame, only meaningful with pixel_val
//   img        out  column vector, slot k at img[k*IMG_WIDTH +: IMG_WIDTH]
//   val        out  img qualifier
//   eol        out  high with val on the last column of a row
//
// Build option
//   PIXEL_WINDOW_BORDER_EN  when defined, every accepted pixel yields val;
//                           slots reaching above the top of the frame read 0.
//                           When undefined, val stays low for the first
//                           IMG_NB-1 rows of each frame.
// ---------------------------------------------------------------------------
module pixel_window
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH = CONV_IMG_WIDTH,
    parameter int IMG_NB    = CONV_IMG_NB,
    parameter int IMG_COLS  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IMG_WIDTH-1:0]          pixel,
    input  logic                          pixel_val,
    input  logic                          sof,
    output logic [IMG_WIDTH*IMG_NB-1:0]   img,
    output logic                          val,
    output logic                          eol
);

    localparam int CW = cnt_width(IMG_COLS);
    localparam int RW = cnt_width(IMG_NB);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_NB - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Position of the pixel on the input: sof restarts the frame right here.
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          at_last;

    logic [IMG_NB-2:0][IMG_WIDTH-1:0] line_out;
    logic [IMG_WIDTH*IMG_NB-1:0]      img_next;
    logic                             val_next;

    assign cur_col = sof ? '0 : col;
    assign cur_row = sof ? '0 : row;
    assign at_last = (cur_col == COL_LAST);

    // Delay k is fed by delay k-1, so its content is one more row old.
    for (genvar k = 0; k < IMG_NB - 1; k++) begin : g_delay
        line_buffer #(
            .IMG_WIDTH (IMG_WIDTH),
            .IMG_COLS  (IMG_COLS)
        ) u_line (
            .clk   (clk),
            .wr_en (pixel_val),
            .addr  (cur_col),
            .din   ((k == 0) ? pixel : line_out[(k == 0) ? 0 : k - 1]),
            .dout  (line_out[k])
        );
    end

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        img_next = '0;
        img_next[0 +: IMG_WIDTH] = pixel;
        for (int k = 1; k < IMG_NB; k++) begin
`ifdef PIXEL_WINDOW_BORDER_EN
            // Rows above the top of the frame read as zero.
            if (k <= int'(cur_row)) begin
                img_next[k*IMG_WIDTH +: IMG_WIDTH] = line_out[k-1];
            end
`else
            img_next[k*IMG_WIDTH +: IMG_WIDTH] = line_out[k-1];
`endif
        end
    end

`ifdef PIXEL_WINDOW_BORDER_EN
    assign val_next = 1'b1;
`else
    // row saturates at IMG_NB-1, so this is "enough rows accumulated".
    assign val_next = (cur_row >= ROW_LAST);
`endif

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img <= '0;
            val <= 1'b0;
            eol <= 1'b0;
            col <= '0;
            row <= '0;
        end else if (pixel_val) begin
            img <= img_next;
            val <= val_next;
            eol <= val_next && at_last;
            if (at_last) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? cur_row : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end else begin
            // Idle cycle: img and counters hold, qualifiers drop.
            val <= 1'b0;
            eol <= 1'b0;
        end
    end

endmodule : pixel_window

// File: doc/pixel_window.md
PIXEL_WINDOW -- requirements
Module: pixel_window

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 16, the pixel bit width.
REQ-002 The block SHALL have parameter IMG_NB, default 3, the rows per output column vector (≥2).
REQ-003 The block SHALL have parameter IMG_COLS, default 64, the pixels per image row (≥2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port pixel, input, IMG_WIDTH bits: raster-order input pixel.
REQ-007 The block SHALL have port pixel_val, input, 1 bit: pixel qualifier.
REQ-008 The block SHALL have port sof, input, 1 bit: start of frame, meaningful only with pixel_val.
REQ-009 The block SHALL have port img, output, IMG_WIDTH*IMG_NB bits: column vector for the downstream convolution stage.
REQ-010 The block SHALL have port val, output, 1 bit: img qualifier, driving the downstream stage's val.
REQ-011 The block SHALL have port eol, output, 1 bit: high with val when the emitted column is the last of its row.

Function
REQ-012 The block SHALL place slot k at img[k*IMG_WIDTH +: IMG_WIDTH]; slot 0 is the current pixel; slot k is the pixel at the same column, k rows earlier.
REQ-013 The block SHALL keep IMG_NB-1 row delays of IMG_COLS entries each, addressed by column counter col.
REQ-014 On a pixel_val cycle, the block SHALL read all row delays at col before writing; delay 0 takes pixel, and delay k takes the old value of delay k-1.
REQ-015 The block SHALL have latency of exactly 1 cycle: img, val and eol are registered, updating on the edge that accepts the pixel.
REQ-016 The block SHALL raise val for one cycle per accepted pixel when the row counter row ≥ IMG_NB-1.
REQ-017 The block SHALL hold val and eol low in cycles without pixel_val.
REQ-018 When pixel_val is low, the block SHALL hold img and all counters and leave the row delays unchanged.
REQ-019 On column wrap at col = IMG_COLS-1, the block SHALL set col to 0 and increment row, saturating at IMG_NB-1.
REQ-020 When pixel_val and sof are both high, the block SHALL treat the pixel as col 0, row 0; afterwards col = 1, row = 0, including when sof arrives mid-row or mid-frame.
REQ-021 When sof is high without pixel_val, the block SHALL ignore it.
REQ-022 The block SHALL set eol = val AND (col of emitted pixel = IMG_COLS-1).
REQ-023 The block SHALL have row delay contents that are not reset; only row gating makes stale data invisible.

Reset
REQ-024 The block SHALL, on rst asserted, immediately set img = 0, val = 0, eol = 0, col = 0, row = 0, regardless of clock.
REQ-025 The block SHALL, after rst release, treat the first accepted pixel as col 0 of row 0, whether or not sof is present.
REQ-026 The block SHALL, when rst is asserted mid-frame, discard the partial frame; no val until IMG_NB-1 complete rows are re-accumulated.

Configuration
REQ-027 The block SHALL recognise macro PIXEL_WINDOW_BORDER_EN.
REQ-028 With PIXEL_WINDOW_BORDER_EN defined, the block SHALL raise val for every accepted pixel, including rows 0..IMG_NB-2, with slot k forced to 0 when k > row.
REQ-029 Without PIXEL_WINDOW_BORDER_EN, the block SHALL emit no val for the first IMG_NB-1 rows of a frame, and slots SHALL never be zero-forced.

Structure
REQ-030 The block SHALL take defaults for IMG_WIDTH and IMG_NB, and a counter width function ($clog2-based), from shared package conv_pkg, which the convolution stages also use.
REQ-031 The block SHALL implement each row delay as sub-module line_buffer (parameters IMG_WIDTH, IMG_COLS; ports clk, wr_en, addr, din, dout), instantiated IMG_NB-1 times in a generate loop.
REQ-032 The block SHALL implement line_buffer as an inferred simple dual-port RAM with read-before-write semantics.

Verification
REQ-033 The bench SHALL run IMG_COLS = 4, IMG_NB = 3, pixels 1..16 continuous, sof with pixel 1 -> no val for pixels 1..8; cycle after pixel 9: val = 1, img slots {0,1,2} = {9,5,1}; after pixel 12: slots {12,8,4}, eol = 1.
REQ-034 The bench SHALL repeat REQ-033 with pixel_val low every other cycle -> identical img/val/eol sequence, val never high in idle-follow cycles, img held.
REQ-035 The bench SHALL assert sof with pixel 7 of the frame -> val low until 8 further pixels are accepted; next val carries slots {pixel, pixel-4, 7}.
REQ-036 The bench SHALL assert rst asynchronously during pixel 10 -> outputs 0 within the same cycle; restart with sof reproduces REQ-033 exactly.
REQ-037 The bench SHALL run PIXEL_WINDOW_BORDER_EN defined, stream as REQ-033 -> pixel 1: val = 1, slots {1,0,0}; pixel 5: slots {5,1,0}; pixel 9: slots {9,5,1}.
REQ-038 The bench SHALL drive sof without pixel_val mid-row -> no change to col/row; subsequent outputs match an undisturbed stream.
